// File: rtl/cfg_tgate_mux.sv
// rtl/cfg_tgate_mux.sv - configurable transmission-gate routing mux with serial config chain
//
// Purpose:
//   NUM_IN-input routing multiplexer for connection/switch blocks. A config word
//   {enable, select} is shifted in on the programming chain (ccff_head -> ccff_tail),
//   then committed atomically into a shadow register that drives the datapath.
//   A disabled mux, or one with an out-of-range select, drives a defined 0.
//
// Optional build macro:
//   CFG_MUX_OUTREG_EN - when defined, out/out_en/sel_err are registered on prog_clk
//                       (1-cycle latency, async reset to 0). Undefined: combinational.
//
// Ports:
//   prog_clk      in   programming clock (single domain)
//   prog_reset_n  in   asynchronous active-low reset
//   ccff_head     in   serial config data in
//   cfg_shift_en  in   shift enable for the config shift register
//   cfg_commit    in   copy shift register into shadow (honoured only when cfg_ready)
//   ccff_tail     out  serial config data out (shift register MSB)
//   cfg_ready     out  a full config word has been shifted since last commit/reset
//   in            in   NUM_IN data inputs
//   out           out  mux output
//   out_en        out  committed enable bit
//   sel_err       out  committed select is out of range

module cfg_tgate_mux #(
  parameter int NUM_IN  = 4,
  parameter bit OUT_INV = 1'b0
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              ccff_head,
  input  logic              cfg_shift_en,
  input  logic              cfg_commit,
  output logic              ccff_tail,
  output logic              cfg_ready,
  input  logic [NUM_IN-1:0] in,
  output logic              out,
  output logic              out_en,
  output logic              sel_err
);

  localparam int SEL_W   = $clog2(NUM_IN);
  localparam int CFG_W   = SEL_W + 1;
  localparam int CNT_W   = $clog2(CFG_W + 1);
  localparam int PAD_W   = 2 ** SEL_W;

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CFG_W);
  localparam logic [SEL_W:0]   NUM_IN_CMP = (SEL_W + 1)'(NUM_IN);

  logic [CFG_W-1:0] shreg_q, shreg_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_ok;

  // Fill state is encoded directly in cnt_q: 0 = EMPTY, 1..CFG_W-1 = PARTIAL,
  // CFG_W = FULL (saturating, extra shifts still move data down the chain).
  assign cfg_ready = (cnt_q == CNT_FULL);
  assign commit_ok = cfg_commit & cfg_ready;
  assign ccff_tail = shreg_q[CFG_W-1];

  always_comb begin
    shreg_d  = shreg_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (cfg_shift_en) begin
      shreg_d = {shreg_q[CFG_W-2:0], ccff_head};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Commit captures the pre-edge word; a shift in the same cycle starts the next word.
    if (commit_ok) begin
      shadow_d = shreg_q;
      cnt_d    = cfg_shift_en ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shreg_q  <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shreg_q  <= shreg_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Datapath
  logic             en;
  logic [SEL_W-1:0] sel;
  logic [PAD_W-1:0] in_pad;
  logic             err_c;
  logic             out_c;

  assign en  = shadow_q[CFG_W-1];
  assign sel = shadow_q[SEL_W-1:0];

  // Zero-extend inputs to a full power-of-two table so every select value indexes a defined bit.
  always_comb begin
    in_pad               = '0;
    in_pad[NUM_IN-1:0]   = in;
  end

  assign err_c = en & ({1'b0, sel} >= NUM_IN_CMP);
  assign out_c = (en & ~err_c) ? (in_pad[sel] ^ OUT_INV) : 1'b0;

`ifdef CFG_MUX_OUTREG_EN
  logic out_q, out_en_q, sel_err_q;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      out_q     <= 1'b0;
      out_en_q  <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= out_c;
      out_en_q  <= en;
      sel_err_q <= err_c;
    end
  end

  assign out     = out_q;
  assign out_en  = out_en_q;
  assign sel_err = sel_err_q;
`else
  assign out     = out_c;
  assign out_en  = en;
  assign sel_err = err_c;
`endif

endmodule

// File: tb/tb_cfg_tgate_mux.sv
// tb/tb_cfg_tgate_mux.sv - directed self-checking bench for cfg_tgate_mux (NUM_IN=5)

module tb_cfg_tgate_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       head = 1'b0;
  logic       shift_en = 1'b0;
  logic       commit = 1'b0;
  logic [4:0] din = 5'b0;

  logic tail0, ready0, out0, en0, err0;
  logic tail1, ready1, out1, en1, err1;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cfg_tgate_mux #(.NUM_IN(5), .OUT_INV(1'b0)) dut0 (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .ccff_head    (head),
    .cfg_shift_en (shift_en),
    .cfg_commit   (commit),
    .ccff_tail    (tail0),
    .cfg_ready    (ready0),
    .in           (din),
    .out          (out0),
    .out_en       (en0),
    .sel_err      (err0)
  );

  cfg_tgate_mux #(.NUM_IN(5), .OUT_INV(1'b1)) dut1 (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .ccff_head    (head),
    .cfg_shift_en (shift_en),
    .cfg_commit   (commit),
    .ccff_tail    (tail1),
    .cfg_ready    (ready1),
    .in           (din),
    .out          (out1),
    .out_en       (en1),
    .sel_err      (err1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One prog_clk edge with the given controls; returns at the following negedge.
  task automatic drive(input logic sh, input logic hd, input logic cm);
    @(negedge clk);
    shift_en = sh;
    head     = hd;
    commit   = cm;
    @(negedge clk);
    shift_en = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic shift_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) drive(1'b1, w[i], 1'b0);
  endtask

  // Let outputs reflect the latest shadow/in values.
  task automatic settle();
`ifdef CFG_MUX_OUTREG_EN
    @(negedge clk);
`else
    #1;
`endif
  endtask

  logic [7:0] stream;

  initial begin
    // Reset state
    #12;
    chk("rst_tail", tail0, 1'b0);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_out_en", en0, 1'b0);
    chk("rst_sel_err", err0, 1'b0);
    chk("rst_out", out0, 1'b0);
    chk("rst_out_inv", out1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // en=1 sel=3
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("ready_after3", ready0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("ready_after4", ready0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("ready_after_commit", ready0, 1'b0);
    din = 5'b01000;
    settle();
    chk("sel3_out", out0, 1'b1);
    chk("sel3_out_en", en0, 1'b1);
    chk("sel3_sel_err", err0, 1'b0);
    chk("sel3_inv_out", out1, 1'b0);
    din = 5'b10111;
    settle();
    chk("sel3_out_low", out0, 1'b0);
    din = 5'b00000;
    settle();
    chk("sel3_inv_out_zero_in", out1, 1'b1);

    // en=1 sel=7: out of range
    shift_word(4'b1111);
    drive(1'b0, 1'b0, 1'b1);
    settle();
    chk("sel7_sel_err", err0, 1'b1);
    chk("sel7_out_en", en0, 1'b1);
    foreach (stream[i]) begin
      din = 5'($urandom_range(0, 31));
      settle();
      chk("sel7_out", out0, 1'b0);
      chk("sel7_inv_out", out1, 1'b0);
    end

    // Partial word: commit ignored
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    settle();
    chk("partial_ready", ready0, 1'b0);
    chk("partial_sel_err_kept", err0, 1'b1);
    chk("partial_out_en_kept", en0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    din = 5'b00100;
    settle();
    chk("sel2_sel_err", err0, 1'b0);
    chk("sel2_out", out0, 1'b1);

    // Commit and shift in the same cycle (en=1 sel=1, then one extra bit)
    shift_word(4'b1001);
    drive(1'b1, 1'b1, 1'b1);
    chk("cs_ready_cnt1", ready0, 1'b0);
    din = 5'b00010;
    settle();
    chk("cs_sel1_out", out0, 1'b1);
    chk("cs_sel1_inv_out", out1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("cs_ready_cnt3", ready0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("cs_ready_cnt4", ready0, 1'b1);

    // Pass-through: tail replays the first bits after CFG_W shifts
    stream = 8'b1001_0110;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, stream[8-k], 1'b0);
      if (k >= 4) chk($sformatf("tail_shift%0d", k), tail0, stream[8-(k-3)]);
    end
    chk("pass_ready_sat", ready0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    din = 5'b11111;
    settle();
    chk("dis_out_en", en0, 1'b0);
    chk("dis_out", out0, 1'b0);
    chk("dis_inv_out", out1, 1'b0);
    chk("dis_sel_err", err0, 1'b0);
    chk("dis_tail_kept", tail0, 1'b0);

    // Async reset mid-shift
    shift_word(4'b1010);
    drive(1'b0, 1'b0, 1'b1);
    din = 5'b00100;
    settle();
    chk("pre_rst_out", out0, 1'b1);
    shift_word(4'b1111);
    chk("pre_rst_ready", ready0, 1'b1);
    chk("pre_rst_tail", tail0, 1'b1);
`ifdef CFG_MUX_OUTREG_EN
    @(negedge clk);
    din = 5'b00000;
    #1;
    chk("outreg_hold", out0, 1'b1);
    @(negedge clk);
    chk("outreg_update", out0, 1'b0);
    din = 5'b00100;
    @(negedge clk);
    chk("outreg_restore", out0, 1'b1);
`endif
    @(negedge clk);
    shift_en = 1'b1;
    head     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", out0, 1'b0);
    chk("arst_out_en", en0, 1'b0);
    chk("arst_ready", ready0, 1'b0);
    chk("arst_tail", tail0, 1'b0);
    chk("arst_inv_out", out1, 1'b0);
    @(negedge clk);
    shift_en = 1'b0;
    rst_n    = 1'b1;
    settle();
    chk("post_rst_out", out0, 1'b0);
    chk("post_rst_tail", tail0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cfg_tgate_mux.md
Name: cfg_tgate_mux

Overview:
- Parametrised routing multiplexer: a NUM_IN-input transmission-gate mux with its own serial configuration register.
- Configuration is shifted in on the programming chain (ccff_head to ccff_tail), then committed atomically into a shadow register that drives the datapath.
- Generalises the single TGATE and buffer/inverter cells into one configurable routing element for connection and switch blocks.

Parameters:
- NUM_IN, 4, number of data inputs; legal range 2..64.
- OUT_INV, 0, 1 = output inverted (tap-buffer style), 0 = true polarity.
- SEL_W, derived localparam = $clog2(NUM_IN), select field width.
- CFG_W, derived localparam = SEL_W + 1, config word width: enable bit plus select.

Ports:
- prog_clk  input  1  programming/config clock; single clock domain
- prog_reset_n  input  1  asynchronous active-low reset
- ccff_head  input  1  serial config data in
- cfg_shift_en  input  1  shift enable for config shift register
- cfg_commit  input  1  request to copy shift register into shadow register
- ccff_tail  output  1  serial config data out (MSB of shift register), for daisy-chaining
- cfg_ready  output  1  exactly CFG_W or more bits shifted since last commit/reset
- in  input  NUM_IN  data inputs
- out  output  1  mux output
- out_en  output  1  committed enable bit
- sel_err  output  1  committed select is out of range

Behaviour:
- Reset, async on prog_reset_n low, released synchronously to prog_clk by the integrator:
  - shreg = 0, shadow = 0, bit_cnt = 0.
  - ccff_tail = 0, cfg_ready = 0, out_en = 0, sel_err = 0, out = 0.
- Shift on a prog_clk edge with cfg_shift_en = 1:
  - shreg <= {shreg[CFG_W-2:0], ccff_head}.
  - ccff_tail = shreg[CFG_W-1], registered, so there is CFG_W cycles of head-to-tail latency.
- Word layout after CFG_W shifts:
  - shreg[CFG_W-1] = enable (first bit shifted in).
  - shreg[SEL_W-1:0] = select, MSB shifted first.
- bit_cnt, width $clog2(CFG_W+1), counts shifts and saturates at CFG_W. Extra shifts keep passing data through the chain. cfg_ready = (bit_cnt == CFG_W).
- Fill FSM, encoded by bit_cnt:
  - EMPTY (cnt 0) -> PARTIAL on shift.
  - PARTIAL -> FULL when cnt reaches CFG_W.
  - FULL stays FULL on shift.
  - Commit in FULL -> EMPTY.
- Commit rules:
  - cfg_commit with cfg_ready = 1: shadow <= shreg (pre-edge value), bit_cnt <= 0.
  - cfg_commit with cfg_ready = 0: ignored; shadow and bit_cnt unchanged.
  - Simultaneous commit and shift while FULL: shadow takes the pre-shift shreg, shreg shifts, bit_cnt <= 1.
  - Commit does not clear shreg; ccff_tail continues unaffected.
- Datapath, combinational from shadow and in, zero latency:
  - en = shadow[CFG_W-1], sel = shadow[SEL_W-1:0].
  - out_en = en.
  - sel_err = en & (sel >= NUM_IN).
  - out = (en & ~sel_err) ? (in[sel] ^ OUT_INV) : 1'b0.
  - Disabled or erroring mux drives a defined 0, never X/Z; this replaces the high-Z of the single TGATE.
- Reset mid-shift: the partial word is discarded, the shadow returns to 0 and out drops to 0 immediately (async).
- Width rules: no truncation of sel; the out-of-range compare uses the full SEL_W bits. For power-of-two NUM_IN, sel_err is constant 0.

Optional Feature:
- CFG_MUX_OUTREG_EN defined:
  - out, out_en and sel_err are registered on prog_clk, giving 1-cycle latency from in/shadow change to outputs.
  - Registered outputs reset to 0 asynchronously.
- CFG_MUX_OUTREG_EN undefined: outputs are purely combinational as above, 0 latency.
- The config path is identical in both builds.

Test Plan:
- NUM_IN=5, OUT_INV=0: reset, then shift 1,0,1,1 (en=1, sel=3), commit, in=5'b01000 -> cfg_ready 1 before commit and 0 after; out=1, out_en=1, sel_err=0. Then in=5'b10111 -> out=0.
- Same config with OUT_INV=1, in=5'b01000 -> out=0; in=5'b00000 -> out=1.
- Shift 1,1,1,1 (sel=7 >= 5), commit -> sel_err=1, out=0 for all in values, out_en=1.
- Shift only 3 bits, assert cfg_commit -> commit ignored, prior outputs unchanged, cfg_ready=0. Shift 1 more bit and commit -> new config takes effect.
- Shift 8 bits 1,0,0,1,0,1,1,0 -> ccff_tail replays the first 4 bits on cycles 5..8. Commit -> shadow = 4'b0110 (en=0), out=0, out_en=0.
- Committed en=1, sel=2, in[2]=1 (out=1), assert prog_reset_n=0 mid-shift -> out, out_en, cfg_ready and ccff_tail go 0 without a clock edge. With CFG_MUX_OUTREG_EN, an in change shows on out one prog_clk later.
